hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter DRAIN_CYCLES, default 3, pipeline drain cycles before halt (1..15).
REQ-002 SHALL have parameter CNT_W, default 16, width of the stall performance counter.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port id_opcode  in  7  opcode of the instruction in ID.
REQ-006 SHALL have ports id_rs1, id_rs2  in  5 each  source register addresses in ID.
REQ-007 SHALL have port ex_rd  in  5  destination register of the instruction in EX.
REQ-008 SHALL have ports ex_memread, ex_regwrite  in  1 each  EX-stage load and register-write flags.
REQ-009 SHALL have port id_branch_taken  in  1  branch-equal resolved taken in ID.
REQ-010 SHALL have port resume  in  1  single-cycle pulse releasing HALT.
REQ-011 SHALL have ports stall, en  out  1 each  ID bubble insert; PC/IF advance enable.
REQ-012 SHALL have port IF_flush_out  out  1  registered flush of the IF/ID instruction.
REQ-013 SHALL have ports halted  out  1  and  stall_cnt  out  CNT_W  halt indication; stall counter.

Function
REQ-014 SHALL implement FSM states RUN, STALL2, DRAIN, HALT.
REQ-015 SHALL define uses_rs2 true for opcodes 0110011, 0100011, 1100011; dep1 = (ex_rd!=0) && (ex_rd==id_rs1 || (uses_rs2 && ex_rd==id_rs2)).
REQ-016 SHALL, in RUN, flag load-use hazard when ex_memread && dep1 for any opcode.
REQ-017 SHALL, in RUN, flag branch hazard when id_opcode==1100011 && ex_regwrite && dep1.
REQ-018 SHALL, on any RUN hazard, drive stall=1, en=0 combinationally in the same cycle.
REQ-019 SHALL go RUN->STALL2 when branch hazard and ex_memread both hold; STALL2 drives stall=1, en=0 for exactly one cycle, then returns to RUN.
REQ-020 SHALL, in RUN with no hazard, drive stall=0, en=1.
REQ-021 SHALL set IF_flush_out=1 for exactly one cycle after a RUN cycle with no hazard and (id_branch_taken or id_opcode==1100111).
REQ-022 SHALL ignore id_branch_taken and jump opcode in any cycle with stall=1 (hazard wins).
REQ-023 SHALL, on id_opcode==0001011 in RUN with no hazard, enter DRAIN with a counter loaded to DRAIN_CYCLES-1.
REQ-024 SHALL, in DRAIN, drive stall=1, en=0, decrement each cycle, and enter HALT when counter is 0.
REQ-025 SHALL, in HALT, drive stall=1, en=0, halted=1; resume=1 returns to RUN and sets IF_flush_out=1 next cycle to discard the sys instruction.
REQ-026 SHALL ignore resume in every state other than HALT.
REQ-027 SHALL drive halted=0 in all states except HALT.

Reset
REQ-028 SHALL, on rst_n low at any time including mid-STALL2/DRAIN/HALT, immediately enter RUN, clear drain counter and IF_flush_out.
REQ-029 SHALL reset output values: stall=0, en=1, IF_flush_out=0, halted=0, stall_cnt=0.

Configuration
REQ-030 SHALL compile the stall counter only when macro HAZ_PERF_CNT_EN is defined.
REQ-031 SHALL, with HAZ_PERF_CNT_EN, increment stall_cnt in each cycle with stall=1 in RUN or STALL2 (not DRAIN/HALT), saturating at all-ones, cleared only by reset.
REQ-032 SHALL, without HAZ_PERF_CNT_EN, keep port stall_cnt and tie it to 0.

Verification
REQ-033 SHALL cover load-use: ex_memread=1, ex_rd=5, id_opcode=0110011, id_rs2=5 -> stall=1, en=0 one cycle; next cycle (EX bubble) en=1.
REQ-034 SHALL cover branch after load: id_opcode=1100011, id_rs1=7, ex_rd=7, ex_memread=1, ex_regwrite=1 -> stall=1 for 2 cycles (RUN then STALL2); stall_cnt=2 with HAZ_PERF_CNT_EN.
REQ-035 SHALL cover taken branch with no hazard: id_branch_taken=1, ex_rd=0 -> IF_flush_out=1 exactly one cycle later, stall=0.
REQ-036 SHALL cover sys: id_opcode=0001011, DRAIN_CYCLES=3 -> en=0 for 3 DRAIN cycles, halted=1 from cycle 4; resume pulse -> RUN, IF_flush_out=1 next cycle, halted=0.
REQ-037 SHALL cover rst_n deassert mid-DRAIN -> outputs immediately stall=0, en=1, halted=0, IF_flush_out=0; resume while in RUN -> no effect.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use/branch stalls, branch/jump IF flush, sys drain-and-halt.
// Optional stall performance counter is built only when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       id_opcode,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic             id_branch_taken,
    input  logic             resume,
    output logic             stall,
    output logic             en,
    output logic             IF_flush_out,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYS    = 7'b0001011;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL2 = 2'd1,
        DRAIN  = 2'd2,
        HALT   = 2'd3
    } state_t;

    state_t     r_state, w_state_nxt;
    logic [3:0] r_drain_cnt, w_drain_cnt_nxt;
    logic       r_flush, w_flush_nxt;

    logic w_uses_rs2, w_dep1, w_load_use, w_branch_haz, w_hazard;

    always_comb begin
        w_uses_rs2   = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) ||
                       (id_opcode == OP_BRANCH);
        w_dep1       = (ex_rd != 5'd0) &&
                       ((ex_rd == id_rs1) || (w_uses_rs2 && (ex_rd == id_rs2)));
        w_load_use   = ex_memread && w_dep1;
        w_branch_haz = (id_opcode == OP_BRANCH) && ex_regwrite && w_dep1;
        w_hazard     = w_load_use || w_branch_haz;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_drain_cnt <= '0;
            r_flush     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
            r_flush     <= w_flush_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_drain_cnt_nxt = r_drain_cnt;
        w_flush_nxt     = 1'b0;
        stall           = 1'b0;
        en              = 1'b1;
        halted          = 1'b0;
        unique case (r_state)
            RUN: begin
                if (w_hazard) begin
                    // A branch waiting on a load needs the load's data one cycle later still.
                    stall = 1'b1;
                    en    = 1'b0;
                    if (w_branch_haz && ex_memread)
                        w_state_nxt = STALL2;
                end else begin
                    w_flush_nxt = id_branch_taken || (id_opcode == OP_JALR);
                    if (id_opcode == OP_SYS) begin
                        w_state_nxt     = DRAIN;
                        w_drain_cnt_nxt = DRAIN_LOAD;
                    end
                end
            end
            STALL2: begin
                stall       = 1'b1;
                en          = 1'b0;
                w_state_nxt = RUN;
            end
            DRAIN: begin
                stall = 1'b1;
                en    = 1'b0;
                if (r_drain_cnt == 4'd0)
                    w_state_nxt = HALT;
                else
                    w_drain_cnt_nxt = r_drain_cnt - 4'd1;
            end
            HALT: begin
                stall  = 1'b1;
                en     = 1'b0;
                halted = 1'b1;
                if (resume) begin
                    w_state_nxt = RUN;
                    w_flush_nxt = 1'b1;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign IF_flush_out = r_flush;

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_cnt_inc;

    // Only hazard stalls are counted; drain/halt time is deliberate, not a hazard.
    assign w_cnt_inc = stall && ((r_state == RUN) || (r_state == STALL2)) &&
                       (r_stall_cnt != '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_cnt_inc)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push expected outputs, a negedge monitor checks them.
module tb_hazard_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [6:0]       id_opcode;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             ex_memread, ex_regwrite, id_branch_taken, resume;
    logic             stall, en, IF_flush_out, halted;
    logic [CNT_W-1:0] stall_cnt;

    typedef struct {
        string            name;
        logic             stall;
        logic             en;
        logic             flush;
        logic             halted;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t             sb_q[$];
    int               checks   = 0;
    int               failures = 0;
    logic [CNT_W-1:0] exp_cnt  = '0;
    bit               done     = 0;

    hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_regwrite(ex_regwrite), .id_branch_taken(id_branch_taken),
        .resume(resume), .stall(stall), .en(en), .IF_flush_out(IF_flush_out),
        .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input string field, input logic [CNT_W-1:0] act,
                       input logic [CNT_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", nm, field, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk(e.name, "stall",  CNT_W'(stall),        CNT_W'(e.stall));
            chk(e.name, "en",     CNT_W'(en),           CNT_W'(e.en));
            chk(e.name, "flush",  CNT_W'(IF_flush_out), CNT_W'(e.flush));
            chk(e.name, "halted", CNT_W'(halted),       CNT_W'(e.halted));
            chk(e.name, "cnt",    stall_cnt,            e.cnt);
        end
    end

    // Drive one cycle of inputs, queue the expected outputs, advance to just after the next edge.
    task automatic step(input string nm, input logic [6:0] op, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [4:0] rd, input logic mr,
                        input logic rw, input logic bt, input logic rs,
                        input logic e_stall, input logic e_en, input logic e_flush,
                        input logic e_halt, input logic counted);
        exp_t e;
        id_opcode = op; id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_memread = mr; ex_regwrite = rw; id_branch_taken = bt; resume = rs;
        e.name = nm; e.stall = e_stall; e.en = e_en; e.flush = e_flush;
        e.halted = e_halt; e.cnt = exp_cnt;
        sb_q.push_back(e);
`ifdef HAZ_PERF_CNT_EN
        if (counted) exp_cnt = exp_cnt + CNT_W'(1);
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string nm, input logic e_flush);
        step(nm, 7'b0110011, 5'd1, 5'd2, 5'd0, 0, 0, 0, 0, 0, 1, e_flush, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        step("reset", 7'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        rst_n = 1'b1;

        idle("idle0", 0);
        // load-use on rs2 of an R-type, then the EX bubble
        step("lu_stall",  7'b0110011, 5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 1, 0, 0, 0, 1);
        step("lu_bubble", 7'b0110011, 5'd1, 5'd5, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("lu_itype_rs2", 7'b0010011, 5'd1, 5'd5, 5'd5, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        step("lu_x0",     7'b0110011, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
        // branch after load: RUN stall then STALL2 (taken ignored while stalled)
        step("bl_run",    7'b1100011, 5'd7, 5'd1, 5'd7, 1, 1, 0, 0, 1, 0, 0, 0, 1);
        step("bl_stall2", 7'b1100011, 5'd7, 5'd1, 5'd0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
        step("br_taken",  7'b1100011, 5'd7, 5'd1, 5'd0, 0, 0, 1, 0, 0, 1, 0, 0, 0);
        idle("br_flush", 1);
        idle("br_flush_end", 0);
        // branch on an ALU result: one stall, taken suppressed
        step("br_alu",    7'b1100011, 5'd1, 5'd9, 5'd9, 0, 1, 1, 0, 1, 0, 0, 0, 1);
        idle("br_alu_noflush", 0);
        step("jalr",      7'b1100111, 5'd2, 5'd3, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("rw_nonbr",  7'b0110011, 5'd3, 5'd4, 5'd3, 0, 1, 0, 0, 0, 1, 1, 0, 0);
        step("resume_run", 7'b0110011, 5'd1, 5'd2, 5'd0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        idle("after_resume_run", 0);
        // sys blocked by a load-use stays in RUN
        step("sys_haz",   7'b0001011, 5'd4, 5'd0, 5'd4, 1, 1, 0, 0, 1, 0, 0, 0, 1);
        idle("sys_haz_run", 0);
        // sys: three drain cycles, then halt until resume
        step("sys",       7'b0001011, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("drain1", 7'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        step("drain2", 7'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("drain3", 7'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("halt1",  7'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        step("halt_resume", 7'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, 0, 0, 1, 0);
        idle("resume_flush", 1);
        idle("resume_flush_end", 0);
        // reset in the middle of DRAIN
        step("sys2",    7'b0001011, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step("drain2_1", 7'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        rst_n   = 1'b0;
        exp_cnt = '0;
        step("rst_mid_drain", 7'b0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        rst_n = 1'b1;
        step("post_rst_resume", 7'b0110011, 5'd1, 5'd2, 5'd0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        idle("post_rst_run", 0);
        idle("post_rst_run2", 0);

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
